// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the dmem_ctrl data-memory front-end.
package dmem_ctrl_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } ctrl_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        wren;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
  } mem_req_t;

  // Size/alignment legality only; the range check depends on ADDR_W and lives in the top.
  function automatic logic bad_shape(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: bad_shape = 1'b0;
      SZ_HALF: bad_shape = lo[0];
      SZ_WORD: bad_shape = (lo != 2'b00);
      default: bad_shape = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte/half lane handling: load extraction with extension, and store merge for RMW.
module dmem_lane_align
  import dmem_ctrl_pkg::*;
(
  input  logic [31:0] mem_word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    shifted  = mem_word >> {lane, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = lane[1] ? mem_word[31:16] : mem_word[15:0];

    case (size)
      SZ_BYTE: load_data = {{24{~uns & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data = {{16{~uns & half_sel[15]}}, half_sel};
      default: load_data = mem_word;
    endcase

    store_word = mem_word;
    case (size)
      SZ_BYTE: store_word[{lane, 3'b000} +: 8] = wdata[7:0];
      SZ_HALF: begin
        if (lane[1]) store_word[31:16] = wdata[15:0];
        else         store_word[15:0]  = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Two-port round-robin front-end for a single-port word memory, with sub-word RMW.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 15
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_p0_req,
  input  logic [31:0] i_p0_addr,
  input  logic        i_p0_wren,
  input  logic [1:0]  i_p0_size,
  input  logic        i_p0_unsigned,
  input  logic [31:0] i_p0_wdata,
  output logic        o_p0_gnt,
  output logic        o_p0_rvalid,
  output logic [31:0] o_p0_rdata,
  output logic        o_p0_err,
  input  logic        i_p1_req,
  input  logic [31:0] i_p1_addr,
  input  logic        i_p1_wren,
  input  logic [1:0]  i_p1_size,
  input  logic        i_p1_unsigned,
  input  logic [31:0] i_p1_wdata,
  output logic        o_p1_gnt,
  output logic        o_p1_rvalid,
  output logic [31:0] o_p1_rdata,
  output logic        o_p1_err,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic        o_mem_wren,
  input  logic [31:0] i_mem_rdata
);

  ctrl_state_t state_q, state_d;
  mem_req_t    req_q, req_mux;
  logic        port_q, last_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [1:0]  gnt;
  logic        acc_err, word_store, mem_we;
  logic [31:0] load_data, store_word;

  // Ties go to the port not granted last; last_q resets to 1 so port 0 wins first.
  always_comb begin
    gnt = 2'b00;
    if (state_q == StIdle && !i_reset) begin
      if (i_p0_req && (!i_p1_req || last_q)) gnt[0] = 1'b1;
      else if (i_p1_req)                     gnt[1] = 1'b1;
    end
    req_mux = gnt[1]
      ? '{addr: i_p1_addr, wren: i_p1_wren, size: i_p1_size, uns: i_p1_unsigned, wdata: i_p1_wdata}
      : '{addr: i_p0_addr, wren: i_p0_wren, size: i_p0_size, uns: i_p0_unsigned, wdata: i_p0_wdata};
  end

  assign acc_err    = bad_shape(req_q.size, req_q.addr[1:0]) || ((req_q.addr >> ADDR_W) != 32'd0);
  assign word_store = req_q.wren && (req_q.size == SZ_WORD);

  dmem_lane_align u_lane_align (
    .mem_word   (i_mem_rdata),
    .lane       (req_q.addr[1:0]),
    .size       (req_q.size),
    .uns        (req_q.uns),
    .wdata      (req_q.wdata),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= StIdle;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (|gnt) state_d = StIssue;
      StIssue: state_d = (acc_err || word_store) ? StDone : StWait;
      StWait:  state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_we      = 1'b0;
    o_mem_addr  = 32'd0;
    o_mem_wdata = 32'd0;
    case (state_q)
      StIssue: if (!acc_err) begin
        o_mem_addr = {req_q.addr[31:2], 2'b00};
        if (word_store) begin
          mem_we      = 1'b1;
          o_mem_wdata = req_q.wdata;
        end
      end
      StWait: begin
        o_mem_addr = {req_q.addr[31:2], 2'b00};
        if (req_q.wren) begin
          mem_we      = 1'b1;
          o_mem_wdata = store_word;
        end
      end
      default: ;
    endcase
    // Reset kills any in-flight write, including the second half of an RMW.
    o_mem_wren = mem_we && !i_reset;

    o_p0_gnt    = gnt[0];
    o_p1_gnt    = gnt[1];
    o_p0_rvalid = (state_q == StDone) && !port_q;
    o_p1_rvalid = (state_q == StDone) && port_q;
    o_p0_rdata  = o_p0_rvalid ? rdata_q : 32'd0;
    o_p1_rdata  = o_p1_rvalid ? rdata_q : 32'd0;
    o_p0_err    = o_p0_rvalid && err_q;
    o_p1_err    = o_p1_rvalid && err_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      req_q   <= '0;
      port_q  <= 1'b0;
      last_q  <= 1'b1;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: if (|gnt) begin
          req_q  <= req_mux;
          port_q <= gnt[1];
          last_q <= gnt[1];
        end
        StIssue: begin
          err_q   <= acc_err;
          rdata_q <= 32'd0;
        end
        StWait: if (!req_q.wren) rdata_q <= load_data;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with a behavioural single-port dmem model.
module tb_dmem_ctrl;
  import dmem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [31:0] addr [2];
  logic [1:0]  wren;
  logic [1:0]  size [2];
  logic [1:0]  uns;
  logic [31:0] wdata [2];
  logic [1:0]  gnt, rvalid, err;
  logic [31:0] rdata [2];
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_wren;
  logic [31:0] dmem [8192];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.ADDR_W(15)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_p0_req(req[0]), .i_p0_addr(addr[0]), .i_p0_wren(wren[0]), .i_p0_size(size[0]),
    .i_p0_unsigned(uns[0]), .i_p0_wdata(wdata[0]), .o_p0_gnt(gnt[0]), .o_p0_rvalid(rvalid[0]),
    .o_p0_rdata(rdata[0]), .o_p0_err(err[0]),
    .i_p1_req(req[1]), .i_p1_addr(addr[1]), .i_p1_wren(wren[1]), .i_p1_size(size[1]),
    .i_p1_unsigned(uns[1]), .i_p1_wdata(wdata[1]), .o_p1_gnt(gnt[1]), .o_p1_rvalid(rvalid[1]),
    .o_p1_rdata(rdata[1]), .o_p1_err(err[1]),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_wren(mem_wren),
    .i_mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_wren) dmem[mem_addr[14:2]] <= mem_wdata;
    else          mem_rdata <= dmem[mem_addr[14:2]];
  end

  // Caller starts just after a posedge; returns just after the posedge following completion.
  task automatic access(input int p, input logic [31:0] a, input logic we, input logic [1:0] sz,
                        input logic u, input logic [31:0] wd, output logic [31:0] rd,
                        output logic er, output int rv_cyc, output int wr_cnt, output int wr_cyc,
                        output int gwait);
    rd = 32'hx; er = 1'bx; rv_cyc = -1; wr_cnt = 0; wr_cyc = -1; gwait = 0;
    addr[p] = a; wren[p] = we; size[p] = sz; uns[p] = u; wdata[p] = wd; req[p] = 1'b1;
    forever begin
      @(negedge clk);
      if (gnt[p]) break;
      gwait++;
      if (gwait > 20) begin
        req[p] = 1'b0;
        return;
      end
    end
    if (mem_wren) wr_cnt++;
    @(posedge clk); #1;
    req[p] = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_wren) begin
        wr_cnt++;
        wr_cyc = c;
      end
      if (rvalid[p]) begin
        rv_cyc = c; rd = rdata[p]; er = err[p];
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({gnt, rvalid, err, mem_wren} !== 7'd0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b want 0", {gnt, rvalid, err, mem_wren});
    end
    vectors++;
    if ({rdata[0], rdata[1], mem_addr, mem_wdata} !== 128'd0) begin
      miscompares++;
      $display("FAIL reset_data: got %h want 0", {rdata[0], rdata[1], mem_addr, mem_wdata});
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_word_round_trip();
    logic [31:0] rd; logic er; int rv, wc, wcy, gw;
    access(0, 32'h100, 1'b1, SZ_WORD, 1'b0, 32'hDEADBEEF, rd, er, rv, wc, wcy, gw);
    vectors++;
    if (rv !== 2 || er !== 1'b0 || wc !== 1 || wcy !== 1) begin
      miscompares++;
      $display("FAIL word_store: rv=%0d err=%b wr=%0d@%0d want rv=2 err=0 wr=1@1", rv, er, wc, wcy);
    end
    vectors++;
    if (dmem[32'h100 >> 2] !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL word_store_mem: got %h want deadbeef", dmem[32'h100 >> 2]);
    end
    access(0, 32'h100, 1'b0, SZ_WORD, 1'b0, 32'h0, rd, er, rv, wc, wcy, gw);
    vectors++;
    if (rv !== 3 || er !== 1'b0 || rd !== 32'hDEADBEEF || wc !== 0) begin
      miscompares++;
      $display("FAIL word_load: rv=%0d err=%b rd=%h wr=%0d want rv=3 err=0 rd=deadbeef wr=0",
               rv, er, rd, wc);
    end
  endtask

  task automatic test_lone_p1();
    logic [31:0] rd; logic er; int rv, wc, wcy, gw;
    access(1, 32'h100, 1'b0, SZ_WORD, 1'b0, 32'h0, rd, er, rv, wc, wcy, gw);
    vectors++;
    if (gw !== 0 || rv !== 3 || rd !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL lone_p1: wait=%0d rv=%0d rd=%h want wait=0 rv=3 rd=deadbeef", gw, rv, rd);
    end
  endtask

  task automatic test_load_extension();
    logic [31:0] rd; logic er; int rv, wc, wcy, gw;
    logic [31:0] exp [3] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF};
    logic [31:0] ad  [3] = '{32'h23, 32'h23, 32'h22};
    logic [1:0]  sz  [3] = '{SZ_BYTE, SZ_BYTE, SZ_HALF};
    logic        un  [3] = '{1'b0, 1'b1, 1'b0};
    access(0, 32'h20, 1'b1, SZ_WORD, 1'b0, 32'h80FF7F01, rd, er, rv, wc, wcy, gw);
    for (int i = 0; i < 3; i++) begin
      access(0, ad[i], 1'b0, sz[i], un[i], 32'h0, rd, er, rv, wc, wcy, gw);
      vectors++;
      if (rd !== exp[i] || rv !== 3 || er !== 1'b0) begin
        miscompares++;
        $display("FAIL load_ext[%0d]: rd=%h rv=%0d err=%b want rd=%h rv=3 err=0",
                 i, rd, rv, er, exp[i]);
      end
    end
  endtask

  task automatic test_subword_rmw();
    logic [31:0] rd; logic er; int rv, wc, wcy, gw;
    access(0, 32'h40, 1'b1, SZ_WORD, 1'b0, 32'h11223344, rd, er, rv, wc, wcy, gw);
    access(0, 32'h41, 1'b1, SZ_BYTE, 1'b0, 32'h000000AA, rd, er, rv, wc, wcy, gw);
    vectors++;
    if (wc !== 1 || wcy !== 2 || rv !== 3 || er !== 1'b0) begin
      miscompares++;
      $display("FAIL rmw_byte: wr=%0d@%0d rv=%0d err=%b want wr=1@2 rv=3 err=0", wc, wcy, rv, er);
    end
    vectors++;
    if (dmem[32'h40 >> 2] !== 32'h1122AA44) begin
      miscompares++;
      $display("FAIL rmw_byte_mem: got %h want 1122aa44", dmem[32'h40 >> 2]);
    end
    access(0, 32'h42, 1'b1, SZ_HALF, 1'b0, 32'h0000BEEF, rd, er, rv, wc, wcy, gw);
    vectors++;
    if (wc !== 1 || wcy !== 2 || rv !== 3 || er !== 1'b0) begin
      miscompares++;
      $display("FAIL rmw_half: wr=%0d@%0d rv=%0d err=%b want wr=1@2 rv=3 err=0", wc, wcy, rv, er);
    end
    access(0, 32'h40, 1'b0, SZ_WORD, 1'b0, 32'h0, rd, er, rv, wc, wcy, gw);
    vectors++;
    if (rd !== 32'hBEEFAA44) begin
      miscompares++;
      $display("FAIL rmw_readback: got %h want beefaa44", rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int rv, wc, wcy, gw;
    logic [31:0] ad [4] = '{32'h41, 32'h102, 32'h104, 32'h8000};
    logic [1:0]  sz [4] = '{SZ_HALF, SZ_WORD, 2'b11, SZ_WORD};
    logic        we [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      access(0, ad[i], we[i], sz[i], 1'b0, 32'h12345678, rd, er, rv, wc, wcy, gw);
      vectors++;
      if (er !== 1'b1 || rd !== 32'd0 || rv !== 2 || wc !== 0) begin
        miscompares++;
        $display("FAIL error[%0d]: err=%b rd=%h rv=%0d wr=%0d want err=1 rd=0 rv=2 wr=0",
                 i, er, rd, rv, wc);
      end
    end
  endtask

  task automatic test_arbitration();
    int seq [$];
    logic [3:0] got;
    addr[0] = 32'h100; wren[0] = 1'b0; size[0] = SZ_WORD; uns[0] = 1'b0; wdata[0] = 32'h0;
    addr[1] = 32'h100; wren[1] = 1'b0; size[1] = SZ_WORD; uns[1] = 1'b0; wdata[1] = 32'h0;
    rst = 1'b1;
    req = 2'b11;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 40 && seq.size() < 4; c++) begin
      @(negedge clk);
      if (gnt == 2'b11) seq.push_back(9);
      else if (gnt[0]) seq.push_back(0);
      else if (gnt[1]) seq.push_back(1);
    end
    @(posedge clk); #1;
    req = 2'b00;
    repeat (6) @(posedge clk);
    #1;
    got = 4'hF;
    for (int i = 0; i < seq.size() && i < 4; i++) got[i] = (seq[i] == 1);
    vectors++;
    if (seq.size() != 4 || got !== 4'b1010 || seq.sum() != 2) begin
      miscompares++;
      $display("FAIL arb_order: %0d grants, pattern(bit0=first) %b want 4 grants 1010",
               seq.size(), got);
    end
  endtask

  task automatic test_reset_mid_rmw();
    logic [31:0] rd; logic er; int rv, wc, wcy, gw;
    logic saw_wren = 1'b0;
    logic gnt_seen = 1'b0;
    access(0, 32'h60, 1'b1, SZ_WORD, 1'b0, 32'h55667788, rd, er, rv, wc, wcy, gw);
    addr[0] = 32'h61; wren[0] = 1'b1; size[0] = SZ_BYTE; uns[0] = 1'b0; wdata[0] = 32'h0;
    req[0] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (gnt[0]) begin
        gnt_seen = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    req[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    saw_wren = mem_wren;
    vectors++;
    if (!gnt_seen || saw_wren !== 1'b0 || rvalid !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_rmw_wait: gnt_seen=%b wren=%b rvalid=%b want 1 0 00",
               gnt_seen, saw_wren, rvalid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    access(0, 32'h60, 1'b0, SZ_WORD, 1'b0, 32'h0, rd, er, rv, wc, wcy, gw);
    vectors++;
    if (gw !== 0 || rv !== 3 || wc !== 0) begin
      miscompares++;
      $display("FAIL reset_rmw_idle: wait=%0d rv=%0d wr=%0d want wait=0 rv=3 wr=0", gw, rv, wc);
    end
    vectors++;
    if (rd !== 32'h55667788) begin
      miscompares++;
      $display("FAIL reset_rmw_word: got %h want 55667788", rd);
    end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) dmem[i] = 32'd0;
    for (int p = 0; p < 2; p++) begin
      addr[p] = 32'd0; size[p] = SZ_WORD; wdata[p] = 32'd0;
    end
    wren = 2'b00;
    uns  = 2'b00;
    test_reset();
    test_word_round_trip();
    test_lone_p1();
    test_load_extension();
    test_subword_rmw();
    test_errors();
    test_arbitration();
    test_reset_mid_rmw();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

- Sequencing front-end for the single-port data memory `dmem`, which has a 32-bit word port, a 1-cycle registered read, and a cycle that either writes or reads, never both.
- Shares that port between two requesters: port 0 is the core LSU, port 1 is the debug/DMA master. Arbitration is round-robin.
- Converts byte and halfword accesses to word accesses: sign/zero-extends loads and performs read-modify-write for sub-word stores.
- Flags misaligned and out-of-range accesses without touching memory.

## Interface
Parameters:
- `ADDR_W`, default 15: byte-address bits mapped to memory; 8192 words.

Ports (`X` = 0, 1 for each requester port):
- `i_clk` in 1: clock; the only clock.
- `i_reset` in 1: reset, synchronous, active-high.
- `i_pX_req` in 1: request; held with its fields stable until `o_pX_gnt`.
- `i_pX_addr` in 32: byte address.
- `i_pX_wren` in 1: 1 = store, 0 = load.
- `i_pX_size` in 2: access size; 00 byte, 01 half, 10 word, 11 illegal.
- `i_pX_unsigned` in 1: zero-extend the load result.
- `i_pX_wdata` in 32: store data, LSB-aligned.
- `o_pX_gnt` out 1: request accepted this cycle.
- `o_pX_rvalid` out 1: one-cycle completion pulse; asserted for loads and stores.
- `o_pX_rdata` out 32: load result; valid while `o_pX_rvalid` is high.
- `o_pX_err` out 1: access rejected; valid while `o_pX_rvalid` is high.
- `o_mem_addr` out 32: memory address to `dmem`; bits [1:0] are 0.
- `o_mem_wdata` out 32: memory write word.
- `o_mem_wren` out 1: memory write enable.
- `i_mem_rdata` in 32: memory read word; valid 1 cycle after a read address is presented with `o_mem_wren`=0.

## Operation
- FSM states are IDLE, ISSUE, WAIT and DONE.
- **IDLE**
  - The arbiter grants one requesting port; `o_pX_gnt` is combinational and high only in IDLE.
  - Request fields are latched and the next state is ISSUE.
- **Arbitration**
  - A lone requester always wins.
  - When both ports request, the port not granted last wins.
  - The last-grant pointer resets to 1, so port 0 wins the first tie.
- **Error check** (in ISSUE)
  - An access is an error if size = 11, or half with addr[0]=1, or word with addr[1:0]≠0, or addr[31:ADDR_W]≠0.
  - On error: no memory access, `o_mem_wren`=0, next state DONE with err=1 and rdata=0.
- **ISSUE**
  - `o_mem_addr` = {latched addr[31:2], 2'b00}.
  - Word store: `o_mem_wren`=1 and `o_mem_wdata`=wdata, then DONE.
  - Load or sub-word store: `o_mem_wren`=0, then WAIT.
- **WAIT** (`i_mem_rdata` is valid in this state)
  - Load: select the lane (byte by addr[1:0], half by addr[1]), extend per `unsigned`, register the result into rdata, then DONE.
  - Sub-word store: merge the LSB byte/half of wdata into the read word at that lane, drive `o_mem_wren`=1 with the merged word at the same address, then DONE.
- **DONE**
  - The granted port gets `o_pX_rvalid`=1 for one cycle; the next state is IDLE.
  - The other port's outputs stay 0.
- **Output rules**
  - `o_mem_wren` is 0 in IDLE and DONE.
  - `o_pX_rdata` and `o_pX_err` are 0 whenever `o_pX_rvalid`=0.

## Timing
Cycle 0 is the cycle in which gnt is high.
- Load: rvalid in cycle 3.
- Word store: memory write in cycle 1, rvalid in cycle 2.
- Sub-word store: read in cycle 1, write in cycle 2, rvalid in cycle 3.
- Error: rvalid in cycle 2.
- Next earliest gnt: the cycle after DONE, so a load occupies 4 cycles and a word store 3.
- **Reset**
  - State → IDLE; pointer → 1; all outputs 0.
  - `o_mem_wren` is forced to 0 combinationally during any cycle with `i_reset`=1.
  - A reset mid-transaction aborts it: no rvalid, and no partial RMW write.
- **Simultaneous events**: a request arriving in any state other than IDLE waits; gnt is never given during ISSUE, WAIT or DONE.
- After reset deasserts, the first gnt can occur in the first cycle with `i_reset`=0.

## Structure
- **Package `dmem_ctrl_pkg`**:
  - size codes SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - FSM state enum `ctrl_state_t`;
  - the request struct (addr, wren, size, unsigned, wdata).
- **Sub-module `dmem_lane_align`** (combinational):
  - load path: lane select plus sign/zero extension;
  - store path: lane merge of the byte/half into the read word.
- Arbiter and FSM live in `dmem_ctrl`.

## Test plan
- **Word round trip:** port 0 stores 0xDEADBEEF at 0x100, then loads 0x100.
  - Store: rvalid in cycle 2.
  - Load: rdata=0xDEADBEEF in cycle 3.
  - err=0 throughout.
- **Byte load extension:** word 0x80FF7F01 at 0x20.
  - Load byte 0x23 signed → 0xFFFFFF80; unsigned → 0x00000080.
  - Load half 0x22 signed → 0xFFFF80FF.
- **Sub-word RMW:** word 0x11223344 at 0x40.
  - Store byte 0xAA to 0x41, then store half 0xBEEF to 0x42.
  - Word load of 0x40 → 0xBEEFAA44.
  - Exactly one `o_mem_wren` pulse per store, in cycle 2.
- **Errors:** half at 0x41, word at 0x102, size 11, and address 0x8000 with ADDR_W=15.
  - Each returns err=1, rdata=0, rvalid in cycle 2.
  - `o_mem_wren` never asserts.
- **Arbitration:** both ports request continuously from reset.
  - Grants alternate 0,1,0,1.
  - A lone port-1 request while port 0 is idle is granted immediately.
- **Reset mid-RMW:** assert `i_reset` in the WAIT cycle of a byte store.
  - No write and no rvalid occur.
  - The target word is unchanged.
  - The FSM is in IDLE on the next cycle.
